// File: rtl/touch_event_detector.sv
// Debounces a synchronised touch line on prescaler ticks and classifies each
// accepted press as short or long, with a wrapping press counter.
module touch_event_detector #(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned LONG_TICKS     = 50
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       TICK,
  input  logic       TOUCH_IN,
  output logic       TOUCHED,
  output logic       SHORT_PRESS,
  output logic       LONG_PRESS,
  output logic [7:0] PRESS_COUNT
);

  localparam int unsigned HoldW = $clog2(LONG_TICKS + 1);

  localparam logic [7:0]       DebOne   = 8'd1;
  localparam logic [7:0]       DebLast  = 8'(DEBOUNCE_TICKS - 1);
  localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_TICKS - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_TICKS);

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StDebPress   = 3'd1;
  localparam logic [2:0] StPressed    = 3'd2;
  localparam logic [2:0] StLongHeld   = 3'd3;
  localparam logic [2:0] StDebRelease = 3'd4;

  logic [1:0]       sync_q;
  logic             touch_s;
  logic [2:0]       state_q, state_d;
  logic [7:0]       deb_cnt_q, deb_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             long_flag_q, long_flag_d;
  logic             touched_q, touched_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic [7:0]       count_q, count_d;

  assign touch_s = sync_q[1];

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_flag_d = long_flag_q;
    touched_d   = touched_q;
    count_d     = count_q;
    // Event pulses last exactly one CLK regardless of TICK.
    short_d     = 1'b0;
    long_d      = 1'b0;
    if (TICK) begin
      case (state_q)
        StIdle: begin
          if (touch_s) begin
            state_d   = StDebPress;
            deb_cnt_d = DebOne;
          end
        end
        StDebPress: begin
          if (!touch_s) begin
            state_d   = StIdle;
            deb_cnt_d = '0;
          end else if (deb_cnt_q == DebLast) begin
            state_d     = StPressed;
            deb_cnt_d   = '0;
            touched_d   = 1'b1;
            count_d     = count_q + DebOne;
            hold_cnt_d  = '0;
            long_flag_d = 1'b0;
          end else begin
            deb_cnt_d = deb_cnt_q + DebOne;
          end
        end
        StPressed: begin
          if (!touch_s) begin
            state_d   = StDebRelease;
            deb_cnt_d = DebOne;
          end else if (hold_cnt_q == HoldLast) begin
            state_d     = StLongHeld;
            hold_cnt_d  = HoldMax;
            long_d      = 1'b1;
            long_flag_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HoldOne;
          end
        end
        StLongHeld: begin
          if (!touch_s) begin
            state_d   = StDebRelease;
            deb_cnt_d = DebOne;
          end else begin
            hold_cnt_d = HoldMax;
          end
        end
        StDebRelease: begin
          // A bounce back high resumes the same press without recounting it.
          if (touch_s) begin
            state_d   = long_flag_q ? StLongHeld : StPressed;
            deb_cnt_d = '0;
          end else if (deb_cnt_q == DebLast) begin
            state_d   = StIdle;
            deb_cnt_d = '0;
            touched_d = 1'b0;
            short_d   = !long_flag_q;
          end else begin
            deb_cnt_d = deb_cnt_q + DebOne;
          end
        end
        default: begin
          state_d   = StIdle;
          deb_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      sync_q      <= '0;
      state_q     <= StIdle;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_flag_q <= 1'b0;
      touched_q   <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      sync_q      <= {sync_q[0], TOUCH_IN};
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_flag_q <= long_flag_d;
      touched_q   <= touched_d;
      short_q     <= short_d;
      long_q      <= long_d;
      count_q     <= count_d;
    end
  end

  assign TOUCHED     = touched_q;
  assign SHORT_PRESS = short_q;
  assign LONG_PRESS  = long_q;
  assign PRESS_COUNT = count_q;

endmodule
